// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
// Default widths and the queued write record {destination register, data}.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;
  localparam int NREG   = 2 ** ADDR_W;
  localparam int DEPTH  = 4;

  // One pending register-file write
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dado;
  } entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous write-back FIFO: push at tail, pop at head, one of each per cycle.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
// Exposes every slot with its valid bit so the owner can search pending writes.
module wb_fifo
  import rf_pkg::*;
#(
  parameter type item_t = entry_t,
  parameter int  DEPTH  = 4,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  item_t                   push_dat,
  input  logic                    pop,
  output item_t                   head,
  output logic [PW:0]             count,
  output item_t [DEPTH-1:0]       entries,
  output logic [DEPTH-1:0]        valid,
  output logic [PW-1:0]           wr_ptr
);

  item_t [DEPTH-1:0] mem;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count_nxt;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != (PW+1)'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];
  assign entries = mem;

  // Next occupancy from the accepted push/pop pair
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Slot i is live when its distance from the head is below the occupancy
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
    end
  end

  // Storage needs no reset; liveness comes from the pointers and count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy state, wrapping modulo DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/register_write_ctrl.sv
// Register-file write port driver: arbitrates memory/ALU results, queues, drains one per cycle.
// Push at edge N into an empty queue is popped at N+1 (Esc high that cycle), captured at N+2.
// Memory wins over ALU; the head pops every non-empty cycle, so the port always has room.
module register_write_ctrl
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int DEPTH  = rf_pkg::DEPTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 MemValido,
  input  logic [ADDR_W-1:0]    MemReg,
  input  logic [DATA_W-1:0]    MemDado,
  output logic                 MemPronto,
  input  logic                 AluValido,
  input  logic [ADDR_W-1:0]    AluReg,
  input  logic [DATA_W-1:0]    AluDado,
  output logic                 AluPronto,
  output logic [ADDR_W-1:0]    RegEsc,
  output logic [DATA_W-1:0]    Dado,
  output logic                 Esc,
  input  logic [ADDR_W-1:0]    Fonte1,
  input  logic [ADDR_W-1:0]    Fonte2,
  output logic                 Byp1Valido,
  output logic [DATA_W-1:0]    Byp1Dado,
  output logic                 Byp2Valido,
  output logic [DATA_W-1:0]    Byp2Dado,
  output logic [2**ADDR_W-1:0] Pendente,
  output logic                 Cheio,
  output logic                 Vazio
);

  import rf_pkg::*;

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] dado;
  } wb_entry_t;

  wb_entry_t               push_dat;
  wb_entry_t               head;
  wb_entry_t [DEPTH-1:0]   fifo_ent;
  logic [DEPTH-1:0]        fifo_vld;
  logic [CNT_W-1:0]        count;
  logic [PW-1:0]           wr_ptr;
  logic                    space;
  logic                    push;
  logic                    pop;
  logic [PW-1:0]           idx;

  // A full queue still pops this cycle, so this term is effectively always true
  assign space     = (count < CNT_W'(DEPTH)) | (count != '0);
  assign MemPronto = space & ~Rst;
  assign AluPronto = space & ~MemValido & ~Rst;
  assign push      = (MemValido & MemPronto) | (AluValido & AluPronto);
  assign push_dat  = MemValido ? '{rd: MemReg, dado: MemDado}
                               : '{rd: AluReg, dado: AluDado};
  assign pop       = (count != '0);
  assign Cheio     = (count == CNT_W'(DEPTH));
  assign Vazio     = (count == '0);

  wb_fifo #(
    .item_t (wb_entry_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .entries  (fifo_ent),
    .valid    (fifo_vld),
    .wr_ptr   (wr_ptr)
  );

  // Output stage: load the head whenever the queue is non-empty
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Esc    <= 1'b0;
      RegEsc <= '0;
      Dado   <= '0;
    end else if (pop) begin
      Esc    <= 1'b1;
      RegEsc <= head.rd;
      Dado   <= head.dado;
    end else begin
      Esc    <= 1'b0;
    end
  end

  // Pending flags: every live queue slot plus the write on the port right now
  always_comb begin
    Pendente = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) Pendente[fifo_ent[i].rd] = 1'b1;
    end
    if (Esc) Pendente[RegEsc] = 1'b1;
  end

  // Bypass: output stage first, then queue oldest to newest, so the newest match is left standing
  always_comb begin
    Byp1Valido = 1'b0;
    Byp1Dado   = '0;
    Byp2Valido = 1'b0;
    Byp2Dado   = '0;
    idx        = '0;
    if (Esc && RegEsc == Fonte1) begin
      Byp1Valido = 1'b1;
      Byp1Dado   = Dado;
    end
    if (Esc && RegEsc == Fonte2) begin
      Byp2Valido = 1'b1;
      Byp2Dado   = Dado;
    end
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PW'(k);
      if (fifo_vld[idx] && fifo_ent[idx].rd == Fonte1) begin
        Byp1Valido = 1'b1;
        Byp1Dado   = fifo_ent[idx].dado;
      end
      if (fifo_vld[idx] && fifo_ent[idx].rd == Fonte2) begin
        Byp2Valido = 1'b1;
        Byp2Dado   = fifo_ent[idx].dado;
      end
    end
  end

endmodule

// File: tb/tb_register_write_ctrl.sv
// Directed bench for register_write_ctrl with a write-order scoreboard.
module tb_register_write_ctrl;

  logic        Clk;
  logic        Rst;
  logic        MemValido, AluValido;
  logic [1:0]  MemReg, AluReg;
  logic [31:0] MemDado, AluDado;
  logic        MemPronto, AluPronto;
  logic [1:0]  RegEsc;
  logic [31:0] Dado;
  logic        Esc;
  logic [1:0]  Fonte1, Fonte2;
  logic        Byp1Valido, Byp2Valido;
  logic [31:0] Byp1Dado, Byp2Dado;
  logic [3:0]  Pendente;
  logic        Cheio, Vazio;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] sb_q[$];

  register_write_ctrl dut (
    .Clk(Clk), .Rst(Rst),
    .MemValido(MemValido), .MemReg(MemReg), .MemDado(MemDado), .MemPronto(MemPronto),
    .AluValido(AluValido), .AluReg(AluReg), .AluDado(AluDado), .AluPronto(AluPronto),
    .RegEsc(RegEsc), .Dado(Dado), .Esc(Esc),
    .Fonte1(Fonte1), .Fonte2(Fonte2),
    .Byp1Valido(Byp1Valido), .Byp1Dado(Byp1Dado),
    .Byp2Valido(Byp2Valido), .Byp2Dado(Byp2Dado),
    .Pendente(Pendente), .Cheio(Cheio), .Vazio(Vazio)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: memory wins; the port always has room outside reset
  task automatic queue_expected();
    if (!Rst && MemValido)      sb_q.push_back({MemReg, MemDado});
    else if (!Rst && AluValido) sb_q.push_back({AluReg, AluDado});
  endtask

  // Advance one edge, sample 1ns later, retire any write against the scoreboard
  task automatic tick();
    queue_expected();
    @(posedge Clk);
    #1;
    if (Esc === 1'b1) begin
      if (sb_q.size() == 0) chk("sb_spurious_write", 64'(Esc), 64'd0);
      else chk("sb_write", 64'({RegEsc, Dado}), 64'(sb_q.pop_front()));
    end
  endtask

  task automatic idle_inputs();
    MemValido = 1'b0; AluValido = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; MemValido = 1'b0; AluValido = 1'b0;
    MemReg = '0; MemDado = '0; AluReg = '0; AluDado = '0;
    Fonte1 = '0; Fonte2 = '0;

    // 1: reset with a memory request held
    MemValido = 1'b1; MemReg = 2'd1; MemDado = 32'h55;
    #1;
    chk("rst_mem_pronto_comb", 64'(MemPronto), 64'd0);
    tick(); tick();
    chk("rst_esc", 64'(Esc), 64'd0);
    chk("rst_regesc", 64'(RegEsc), 64'd0);
    chk("rst_dado", 64'(Dado), 64'd0);
    chk("rst_vazio", 64'(Vazio), 64'd1);
    chk("rst_cheio", 64'(Cheio), 64'd0);
    chk("rst_mem_pronto", 64'(MemPronto), 64'd0);
    chk("rst_pendente", 64'(Pendente), 64'd0);
    Rst = 1'b0; idle_inputs();
    tick();
    chk("post_rst_no_write", 64'(Esc), 64'd0);

    // 2: single ALU write and its latency
    AluValido = 1'b1; AluReg = 2'd2; AluDado = 32'hDEADBEEF;
    #1;
    chk("alu_pronto", 64'(AluPronto), 64'd1);
    tick();
    idle_inputs();
    chk("t2_pend_queued", 64'(Pendente), 64'b0100);
    chk("t2_esc_not_yet", 64'(Esc), 64'd0);
    chk("t2_vazio_0", 64'(Vazio), 64'd0);
    tick();
    chk("t2_esc", 64'(Esc), 64'd1);
    chk("t2_regesc", 64'(RegEsc), 64'd2);
    chk("t2_dado", 64'(Dado), 64'hDEADBEEF);
    chk("t2_pend_port", 64'(Pendente), 64'b0100);
    tick();
    chk("t2_esc_off", 64'(Esc), 64'd0);
    chk("t2_pend_clear", 64'(Pendente), 64'd0);
    chk("t2_vazio_1", 64'(Vazio), 64'd1);

    // 3: arbitration, memory first
    MemValido = 1'b1; MemReg = 2'd1; MemDado = 32'h11;
    AluValido = 1'b1; AluReg = 2'd3; AluDado = 32'h33;
    #1;
    chk("arb_mem_pronto", 64'(MemPronto), 64'd1);
    chk("arb_alu_pronto", 64'(AluPronto), 64'd0);
    tick();
    MemValido = 1'b0;
    #1;
    chk("arb_alu_pronto_after", 64'(AluPronto), 64'd1);
    tick();
    idle_inputs();
    chk("arb_first_is_r1", 64'({Esc, RegEsc}), 64'({1'b1, 2'd1}));
    tick();
    chk("arb_second_is_r3", 64'({Esc, RegEsc}), 64'({1'b1, 2'd3}));
    tick(); tick();
    chk("arb_drained", 64'(sb_q.size()), 64'd0);

    // 4: five back-to-back ALU writes
    for (int i = 0; i < 5; i++) begin
      AluValido = 1'b1; AluReg = 2'(i % 4); AluDado = 32'h100 + 32'(i);
      #1;
      chk("stream_alu_pronto", 64'(AluPronto), 64'd1);
      chk("stream_cheio", 64'(Cheio), 64'd0);
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();
    chk("stream_drained", 64'(sb_q.size()), 64'd0);
    chk("stream_vazio", 64'(Vazio), 64'd1);

    // 5: bypass shows the newest value for r2
    Fonte1 = 2'd2; Fonte2 = 2'd3;
    AluValido = 1'b1; AluReg = 2'd2; AluDado = 32'hA;
    #1;
    chk("byp_same_cycle_ignored", 64'(Byp1Valido), 64'd0);
    tick();
    chk("byp_a_vld", 64'(Byp1Valido), 64'd1);
    chk("byp_a_dado", 64'(Byp1Dado), 64'hA);
    AluDado = 32'hB;
    tick();
    idle_inputs();
    chk("byp_b_over_a_vld", 64'(Byp1Valido), 64'd1);
    chk("byp_b_over_a_dado", 64'(Byp1Dado), 64'hB);
    chk("byp2_no_match", 64'({Byp2Valido, Byp2Dado}), 64'd0);
    tick();
    chk("byp_b_port", 64'({Byp1Valido, Byp1Dado}), 64'({1'b1, 32'hB}));
    tick();
    chk("byp_none", 64'({Byp1Valido, Byp1Dado}), 64'd0);

    // 6: reset while a write is on the port and another is queued
    for (int i = 0; i < 3; i++) begin
      AluValido = 1'b1; AluReg = 2'(i + 1); AluDado = 32'hC0 + 32'(i);
      tick();
    end
    idle_inputs();
    chk("mid_esc_high", 64'(Esc), 64'd1);
    Rst = 1'b1;
    sb_q.delete();
    tick();
    Rst = 1'b0;
    chk("mid_rst_esc", 64'(Esc), 64'd0);
    chk("mid_rst_vazio", 64'(Vazio), 64'd1);
    chk("mid_rst_pend", 64'(Pendente), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_writes", 64'(Esc), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
